// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out serializer with valid/ready handshakes on both
//   sides. Each accepted WIDTH-bit word is emitted as BEATS = WIDTH/LANES beats
//   of LANES bits, LSB-first (MSB_FIRST=0) or MSB-first (MSB_FIRST=1).
//   A one-word pending buffer lets consecutive words stream back-to-back with
//   no idle beat between frames.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   clr        in   1      synchronous clear: drops active frame and pending word
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      a word can be accepted this cycle
//   in_data    in   WIDTH  parallel word
//   ser_valid  out  1      ser_data carries a valid beat
//   ser_ready  in   1      downstream accepts the beat
//   ser_data   out  LANES  current beat
//   ser_first  out  1      current beat is beat 0 of a word
//   ser_last   out  1      current beat is beat BEATS-1 of a word
//   busy       out  1      a frame is active or a word is pending
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic [LANES-1:0] ser_data,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((WIDTH % LANES) != 0 || BEATS < 2) begin : g_param_check
    $error("piso_serializer: WIDTH must be a multiple of LANES with at least 2 beats");
  end

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             pend_full, pend_full_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [WIDTH-1:0] pend_reg, pend_nxt;

  logic active;
  logic at_last;
  logic in_fire;
  logic ser_fire;

  // Beat presented at the output end of the shifter.
  function automatic logic [LANES-1:0] head_beat(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1 -: LANES];
    else           return v[LANES-1:0];
  endfunction

  // Move the next beat to the output end, zero filling behind it.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v << LANES;
    else           return v >> LANES;
  endfunction

  assign active   = (state == S_ACTIVE);
  assign at_last  = (beat_cnt == LAST_BEAT);
  // in_ready depends on registered state only, so there is no in_valid path.
  assign in_ready = !pend_full;
  assign in_fire  = in_valid && in_ready;
  assign ser_fire = active && ser_ready;

  assign ser_valid = active;
  assign ser_first = active && (beat_cnt == '0);
  assign ser_last  = active && at_last;
  assign ser_data  = active ? head_beat(shift_reg) : '0;
  assign busy      = active || pend_full;

  // Next-state: clr wins; otherwise a beat transfer drives the frame forward,
  // and an input transfer lands in the shifter (idle / frame end) or in the
  // pending buffer (mid-frame, including a stalled last beat).
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = beat_cnt;
    pend_full_nxt = pend_full;
    shift_nxt     = shift_reg;
    pend_nxt      = pend_reg;

    if (clr) begin
      state_nxt     = S_IDLE;
      cnt_nxt       = '0;
      pend_full_nxt = 1'b0;
    end else if (ser_fire) begin
      if (!at_last) begin
        shift_nxt = advance(shift_reg);
        cnt_nxt   = beat_cnt + CNT_W'(1);
        if (in_fire) begin
          pend_nxt      = in_data;
          pend_full_nxt = 1'b1;
        end
      end else if (pend_full) begin
        // in_ready is low here, so no new word competes for the shifter.
        shift_nxt     = pend_reg;
        cnt_nxt       = '0;
        pend_full_nxt = 1'b0;
      end else if (in_fire) begin
        shift_nxt = in_data;
        cnt_nxt   = '0;
      end else begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    end else if (active) begin
      if (in_fire) begin
        pend_nxt      = in_data;
        pend_full_nxt = 1'b1;
      end
    end else if (in_fire) begin
      shift_nxt = in_data;
      state_nxt = S_ACTIVE;
      cnt_nxt   = '0;
    end
  end

  // ---- control registers (reset) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      pend_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= cnt_nxt;
      pend_full <= pend_full_nxt;
    end
  end

  // ---- data registers (no reset; outputs are gated by the control state) ----
  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
    pend_reg  <= pend_nxt;
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: WIDTH=8 LANES=1 LSB-first; index 1: WIDTH=8 LANES=2 MSB-first.
  logic [1:0] iv = '0, sr = '0, cl = '0;
  logic [7:0] dat [2];
  logic [1:0] ir, sv, sf, sl, bz;
  logic [0:0] sd0;
  logic [1:0] sd1;

  piso_serializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(cl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(dat[0]),
    .ser_valid(sv[0]), .ser_ready(sr[0]), .ser_data(sd0),
    .ser_first(sf[0]), .ser_last(sl[0]), .busy(bz[0])
  );

  piso_serializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(cl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(dat[1]),
    .ser_valid(sv[1]), .ser_ready(sr[1]), .ser_data(sd1),
    .ser_first(sf[1]), .ser_last(sl[1]), .busy(bz[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] get_sd(input int d);
    return (d == 0) ? {1'b0, sd0} : sd1;
  endfunction

  function automatic int bcount(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  // Reference model: the list of beats still owed to the downstream side.
  typedef struct packed { logic [1:0] d; bit f; bit l; } beat_t;
  beat_t mq[$];

  task automatic push_word(input int d, input logic [7:0] w);
    int lanes, nb;
    beat_t b;
    logic [7:0] mask;
    lanes = (d == 0) ? 1 : 2;
    nb    = bcount(d);
    mask  = 8'((1 << lanes) - 1);
    for (int k = 0; k < nb; k++) begin
      if (d == 1) b.d = 2'((w >> (8 - (k + 1) * lanes)) & mask);
      else        b.d = 2'((w >> (k * lanes)) & mask);
      b.f = (k == 0);
      b.l = (k == nb - 1);
      mq.push_back(b);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance it.
  task automatic tick(input int d, output bit acc, output bit vis, output bit lst);
    int b;
    bit infire, serfire;
    b = bcount(d);
    @(negedge clk);
    chk($sformatf("d%0d in_ready", d), 32'(ir[d]), 32'(mq.size() <= b));
    chk($sformatf("d%0d busy", d),     32'(bz[d]), 32'(mq.size() != 0));
    chk($sformatf("d%0d ser_valid", d), 32'(sv[d]), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk($sformatf("d%0d ser_data", d),  32'(get_sd(d)), 32'(mq[0].d));
      chk($sformatf("d%0d ser_first", d), 32'(sf[d]), 32'(mq[0].f));
      chk($sformatf("d%0d ser_last", d),  32'(sl[d]), 32'(mq[0].l));
    end else begin
      chk($sformatf("d%0d idle_data", d), 32'(get_sd(d)), 32'd0);
      chk($sformatf("d%0d idle_fl", d),   32'({sf[d], sl[d]}), 32'd0);
    end
    vis = sv[d];
    lst = sl[d];
    infire  = iv[d] && (mq.size() <= b);
    serfire = (mq.size() != 0) && sr[d];
    @(posedge clk);
    if (cl[d]) mq.delete();
    else begin
      if (serfire) void'(mq.pop_front());
      if (infire) push_word(d, dat[d]);
    end
    acc = infire && !cl[d];
    #1;
  endtask

  task automatic drain(input int d);
    bit a, v, l;
    int n;
    iv[d] = 1'b0; cl[d] = 1'b0; sr[d] = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 40) begin
      tick(d, a, v, l);
      n++;
    end
    tick(d, a, v, l);
    chk($sformatf("d%0d drain_idle", d), 32'(bz[d]), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d ser_valid", tag, d), 32'(sv[d]), 32'd0);
      chk($sformatf("%s d%0d ser_data", tag, d),  32'(get_sd(d)), 32'd0);
      chk($sformatf("%s d%0d first_last", tag, d), 32'({sf[d], sl[d]}), 32'd0);
      chk($sformatf("%s d%0d busy", tag, d),      32'(bz[d]), 32'd0);
      chk($sformatf("%s d%0d in_ready", tag, d),  32'(ir[d]), 32'd1);
    end
  endtask

  typedef struct {
    int d; bit iv; logic [7:0] data; bit sr; bit clr;
    bit ev; logic [1:0] ed; bit ef; bit el; bit eir; bit ebz;
  } vec_t;
  vec_t vt[16];

  logic [7:0] words [3];
  bit ta, tv, tl;
  int idx, nb, cyc, first_cyc, last_cyc, lasts, badlast;
  logic [1:0] hold_d;
  bit hold_f, hold_l;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dat[0] = '0; dat[1] = '0;

    // A5 LSB-first on 1 lane, then B4 MSB-first on 2 lanes.
    vt[0]  = '{0, 1, 8'hA5, 1, 0,  0, 2'd0, 0, 0, 1, 0};
    vt[1]  = '{0, 0, 8'h00, 1, 0,  1, 2'd1, 1, 0, 1, 1};
    vt[2]  = '{0, 0, 8'h00, 1, 0,  1, 2'd0, 0, 0, 1, 1};
    vt[3]  = '{0, 0, 8'h00, 1, 0,  1, 2'd1, 0, 0, 1, 1};
    vt[4]  = '{0, 0, 8'h00, 1, 0,  1, 2'd0, 0, 0, 1, 1};
    vt[5]  = '{0, 0, 8'h00, 1, 0,  1, 2'd0, 0, 0, 1, 1};
    vt[6]  = '{0, 0, 8'h00, 1, 0,  1, 2'd1, 0, 0, 1, 1};
    vt[7]  = '{0, 0, 8'h00, 1, 0,  1, 2'd0, 0, 0, 1, 1};
    vt[8]  = '{0, 0, 8'h00, 1, 0,  1, 2'd1, 0, 1, 1, 1};
    vt[9]  = '{0, 0, 8'h00, 1, 0,  0, 2'd0, 0, 0, 1, 0};
    vt[10] = '{1, 1, 8'hB4, 1, 0,  0, 2'd0, 0, 0, 1, 0};
    vt[11] = '{1, 0, 8'h00, 1, 0,  1, 2'b10, 1, 0, 1, 1};
    vt[12] = '{1, 0, 8'h00, 1, 0,  1, 2'b11, 0, 0, 1, 1};
    vt[13] = '{1, 0, 8'h00, 1, 0,  1, 2'b01, 0, 0, 1, 1};
    vt[14] = '{1, 0, 8'h00, 1, 0,  1, 2'b00, 0, 1, 1, 1};
    vt[15] = '{1, 0, 8'h00, 1, 0,  0, 2'd0, 0, 0, 1, 0};

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single-word frames.
    for (int i = 0; i < 16; i++) begin
      iv[vt[i].d] = vt[i].iv; dat[vt[i].d] = vt[i].data;
      sr[vt[i].d] = vt[i].sr; cl[vt[i].d] = vt[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d ser_valid", i), 32'(sv[vt[i].d]), 32'(vt[i].ev));
      chk($sformatf("vec%0d ser_data", i),  32'(get_sd(vt[i].d)), 32'(vt[i].ed));
      chk($sformatf("vec%0d ser_first", i), 32'(sf[vt[i].d]), 32'(vt[i].ef));
      chk($sformatf("vec%0d ser_last", i),  32'(sl[vt[i].d]), 32'(vt[i].el));
      chk($sformatf("vec%0d in_ready", i),  32'(ir[vt[i].d]), 32'(vt[i].eir));
      chk($sformatf("vec%0d busy", i),      32'(bz[vt[i].d]), 32'(vt[i].ebz));
      @(posedge clk);
      #1;
    end
    iv = '0; cl = '0; sr = '0;

    // Back-to-back words with in_valid held.
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    idx = 0; nb = 0; cyc = 0; first_cyc = -1; last_cyc = 0; lasts = 0; badlast = 0;
    sr[0] = 1'b1;
    while ((idx < 3 || mq.size() != 0) && cyc < 60) begin
      iv[0]  = (idx < 3);
      dat[0] = (idx < 3) ? words[idx] : 8'h00;
      tick(0, ta, tv, tl);
      if (tv) begin
        nb++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (tl) begin
          lasts++;
          if (nb % 8 != 0) badlast++;
        end
      end
      if (ta) idx++;
      cyc++;
    end
    chk("b2b_beats", 32'(nb), 32'd24);
    chk("b2b_span", 32'(last_cyc - first_cyc + 1), 32'd24);
    chk("b2b_lasts", 32'(lasts), 32'd3);
    chk("b2b_last_pos", 32'(badlast), 32'd0);
    drain(0);

    // Stall at beat 3 of 0x3C.
    iv[0] = 1'b1; dat[0] = 8'h3C; sr[0] = 1'b1;
    tick(0, ta, tv, tl);
    iv[0] = 1'b0;
    repeat (3) tick(0, ta, tv, tl);
    hold_d = get_sd(0); hold_f = sf[0]; hold_l = sl[0];
    chk("stall_beat3_data", 32'(hold_d), 32'd1);
    sr[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(0, ta, tv, tl);
      chk("stall_data_stable", 32'(get_sd(0)), 32'(hold_d));
      chk("stall_fl_stable", 32'({sf[0], sl[0]}), 32'({hold_f, hold_l}));
      chk("stall_valid", 32'(sv[0]), 32'd1);
    end
    drain(0);

    // clr at beat 5 with a word pending; the in-flight input is discarded.
    iv[0] = 1'b1; dat[0] = 8'h96; sr[0] = 1'b1;
    tick(0, ta, tv, tl);
    iv[0] = 1'b0;
    repeat (2) tick(0, ta, tv, tl);
    iv[0] = 1'b1; dat[0] = 8'h77;
    tick(0, ta, tv, tl);
    iv[0] = 1'b0;
    repeat (2) tick(0, ta, tv, tl);
    chk("clr_pre_in_ready", 32'(ir[0]), 32'd0);
    cl[0] = 1'b1; iv[0] = 1'b1; dat[0] = 8'hEE;
    tick(0, ta, tv, tl);
    cl[0] = 1'b0; iv[0] = 1'b0;
    chk("clr_ser_valid", 32'(sv[0]), 32'd0);
    chk("clr_busy", 32'(bz[0]), 32'd0);
    chk("clr_in_ready", 32'(ir[0]), 32'd1);
    tick(0, ta, tv, tl);
    iv[0] = 1'b1; dat[0] = 8'h69;
    tick(0, ta, tv, tl);
    drain(0);

    // Randomised traffic on both configurations.
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 400; c++) begin
        iv[d]  = ($urandom_range(3) != 0);
        dat[d] = 8'($urandom);
        sr[d]  = ($urandom_range(3) != 0);
        cl[d]  = ($urandom_range(39) == 0);
        tick(d, ta, tv, tl);
      end
      drain(d);
    end

    // Asynchronous reset between clock edges, mid-frame.
    iv[0] = 1'b1; dat[0] = 8'hC3; sr[0] = 1'b1;
    tick(0, ta, tv, tl);
    iv[0] = 1'b0;
    repeat (3) tick(0, ta, tv, tl);
    chk("pre_async_busy", 32'(bz[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    @(posedge clk);
    #1;
    iv[0] = 1'b1; dat[0] = 8'h5A;
    tick(0, ta, tv, tl);
    drain(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
